sd_kin_ramp_ctrl: RTL and testbench

- Sequencing controller for the three-phase sigma-delta bitstream array.
- Accepts frequency-word commands over a valid/ready handshake and holds the array in reset for a fixed startup interval.
- Slews the shared kin word toward each new target so the modulators never see a step larger than the programmed ramp step.
- Monitors the 3-bit phase output for illegal all-low/all-high patterns and forces the array back into reset on a persistent fault.

---
 rtl/sd_ctrl_pkg.sv | 18 +
 rtl/sd_kin_slew.sv | 30 +++
 rtl/sd_kin_ramp_ctrl.sv | 147 ++++++++++++++
 tb/tb_sd_kin_ramp_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sd_ctrl_pkg.sv
// Shared types and constants for the sigma-delta kin ramp controller.
package sd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } sd_state_e;

  localparam logic [2:0] SD_ALL_LOW  = 3'b000;
  localparam logic [2:0] SD_ALL_HIGH = 3'b111;

  localparam int SD_HOLD_CYCLES_DEF = 16;
  localparam int SD_FAULT_LIMIT_DEF = 8;

endpackage

// File: rtl/sd_kin_slew.sv
// Combinational next-kin step: moves kin by at most step toward target; step of 0 jumps.
module sd_kin_slew #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] i_kin,
  input  logic [BITWIDTH-1:0] i_target,
  input  logic [BITWIDTH-1:0] i_step,
  output logic [BITWIDTH-1:0] o_kin_nxt,
  output logic                o_done
);

  logic [BITWIDTH:0] w_diff;
  logic [BITWIDTH:0] w_mag;
  logic              w_neg;

  // One extra bit so target - kin cannot wrap across the full signed range.
  assign w_diff = {i_target[BITWIDTH-1], i_target} - {i_kin[BITWIDTH-1], i_kin};
  assign w_neg  = w_diff[BITWIDTH];
  assign w_mag  = w_neg ? (~w_diff + 1'b1) : w_diff;

  assign o_done = (i_step == '0) || (w_mag <= {1'b0, i_step});

  always_comb begin
    o_kin_nxt = i_target;
    if (!o_done) begin
      o_kin_nxt = w_neg ? (i_kin - i_step) : (i_kin + i_step);
    end
  end

endmodule

// File: rtl/sd_kin_ramp_ctrl.sv
// Startup hold, kin slewing and phase-fault supervision for the sigma-delta array.
// Fault monitor, FAULT state and fault counters are built only with SD_FAULT_MON_EN defined.
module sd_kin_ramp_ctrl
  import sd_ctrl_pkg::*;
#(
  parameter int BITWIDTH    = 32,
  parameter int HOLD_CYCLES = SD_HOLD_CYCLES_DEF,
  parameter int FAULT_LIMIT = SD_FAULT_LIMIT_DEF,
  parameter int CNT_W       = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [BITWIDTH-1:0] i_cmd_kin,
  input  logic [BITWIDTH-1:0] i_cmd_step,
  input  logic                i_clear_fault,
  input  logic [2:0]          i_sd_out,
  output logic                o_sd_reset,
  output logic [BITWIDTH-1:0] o_kin,
  output logic                o_busy,
  output logic                o_locked,
  output logic                o_fault,
  output logic [CNT_W-1:0]    o_fault_count
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  sd_state_e           r_state;
  sd_state_e           w_state_nxt;
  logic [HW-1:0]       r_hold_cnt;
  logic [BITWIDTH-1:0] r_target;
  logic [BITWIDTH-1:0] r_step;
  logic [BITWIDTH-1:0] r_kin;
  logic                r_sd_reset;
  logic                r_busy;
  logic                r_locked;
  logic [BITWIDTH-1:0] w_slew_kin;
  logic                w_slew_done;
  logic                w_accept;
  logic                w_trip;
  logic                w_clear;

  sd_kin_slew #(.BITWIDTH(BITWIDTH)) u_slew (
    .i_kin     (r_kin),
    .i_target  (r_target),
    .i_step    (r_step),
    .o_kin_nxt (w_slew_kin),
    .o_done    (w_slew_done)
  );

`ifdef SD_FAULT_MON_EN
  localparam int BW = $clog2(FAULT_LIMIT) + 1;

  logic [BW-1:0]    r_bad_cnt;
  logic             r_fault;
  logic [CNT_W-1:0] r_fault_count;
  logic             w_illegal;

  assign w_illegal = (i_sd_out == SD_ALL_LOW) || (i_sd_out == SD_ALL_HIGH);
  assign w_trip    = (r_state == ST_RUN) && w_illegal && (r_bad_cnt == BW'(FAULT_LIMIT - 1));
  assign w_clear   = i_clear_fault;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_bad_cnt     <= '0;
      r_fault       <= 1'b0;
      r_fault_count <= '0;
    end else begin
      // Only an uninterrupted stay in RUN accumulates; any state change restarts the run.
      if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
        r_bad_cnt <= w_illegal ? (r_bad_cnt + 1'b1) : '0;
      end else begin
        r_bad_cnt <= '0;
      end
      r_fault <= (w_state_nxt == ST_FAULT);
      if (w_trip && (r_fault_count != {CNT_W{1'b1}})) begin
        r_fault_count <= r_fault_count + 1'b1;
      end
    end
  end

  assign o_fault       = r_fault;
  assign o_fault_count = r_fault_count;
`else
  logic w_unused;

  assign w_trip        = 1'b0;
  assign w_clear       = 1'b0;
  assign w_unused      = &{1'b0, i_clear_fault, i_sd_out};
  assign o_fault       = 1'b0;
  assign o_fault_count = '0;
`endif

  assign o_cmd_ready = ((r_state == ST_IDLE) || (r_state == ST_RUN)) && !w_trip;
  assign w_accept    = i_cmd_valid && o_cmd_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HOLD:  if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) w_state_nxt = ST_IDLE;
      ST_IDLE:  if (w_accept) w_state_nxt = ST_RAMP;
      ST_RAMP:  if (w_slew_done) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_trip)        w_state_nxt = ST_FAULT;
        else if (w_accept) w_state_nxt = ST_RAMP;
      end
      ST_FAULT: if (w_clear) w_state_nxt = ST_HOLD;
      default:  w_state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= '0;
      r_target   <= '0;
      r_step     <= '0;
      r_kin      <= '0;
      r_sd_reset <= 1'b1;
      r_busy     <= 1'b1;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= ((r_state == ST_HOLD) && (w_state_nxt == ST_HOLD)) ? (r_hold_cnt + 1'b1) : '0;
      if (w_accept) begin
        r_target <= i_cmd_kin;
        r_step   <= i_cmd_step;
      end
      // kin only survives while ramping or running; a retarget from RUN ramps from the held value.
      if ((w_state_nxt == ST_RAMP) || (w_state_nxt == ST_RUN)) begin
        if (r_state == ST_RAMP) r_kin <= w_slew_kin;
      end else begin
        r_kin <= '0;
      end
      r_sd_reset <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_FAULT);
      r_busy     <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_RAMP);
      r_locked   <= (w_state_nxt == ST_RUN);
    end
  end

  assign o_sd_reset = r_sd_reset;
  assign o_kin      = r_kin;
  assign o_busy     = r_busy;
  assign o_locked   = r_locked;

endmodule

// File: tb/tb_sd_kin_ramp_ctrl.sv
// Directed bench for sd_kin_ramp_ctrl; the fault-trip sequence runs when SD_FAULT_MON_EN is defined.
module tb_sd_kin_ramp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_kin;
  logic [31:0] cmd_step;
  logic        clear_fault;
  logic [2:0]  sd_out;
  logic        sd_reset;
  logic [31:0] kin;
  logic        busy;
  logic        locked;
  logic        fault;
  logic [7:0]  fault_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sd_kin_ramp_ctrl dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_kin     (cmd_kin),
    .i_cmd_step    (cmd_step),
    .i_clear_fault (clear_fault),
    .i_sd_out      (sd_out),
    .o_sd_reset    (sd_reset),
    .o_kin         (kin),
    .o_busy        (busy),
    .o_locked      (locked),
    .o_fault       (fault),
    .o_fault_count (fault_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_kin = '0; cmd_step = '0;
    clear_fault = 1'b0; sd_out = 3'b010;
    tick(); tick();
    check("rst_sd_reset", {31'd0, sd_reset}, 32'd1);
    check("rst_kin", kin, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_count", {24'd0, fault_count}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);

    reset = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("hold_sd_reset", {31'd0, sd_reset}, 32'd1);
      check("hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    tick();
    check("idle_sd_reset", {31'd0, sd_reset}, 32'd0);
    check("idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("idle_kin", kin, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Positive ramp 0 -> 0x10000 in 0x4000 steps
    cmd_valid = 1'b1; cmd_kin = 32'h0001_0000; cmd_step = 32'h4000;
    tick();
    cmd_valid = 1'b0;
    check("pos_accept_kin", kin, 32'd0);
    check("pos_accept_busy", {31'd0, busy}, 32'd1);
    check("pos_ready_low", {31'd0, cmd_ready}, 32'd0);
    tick(); check("pos_kin1", kin, 32'h4000);
    tick(); check("pos_kin2", kin, 32'h8000);
    tick(); check("pos_kin3", kin, 32'hC000);
    check("pos_not_locked", {31'd0, locked}, 32'd0);
    tick(); check("pos_kin4", kin, 32'h0001_0000);
    check("pos_locked", {31'd0, locked}, 32'd1);
    check("pos_busy_low", {31'd0, busy}, 32'd0);
    check("pos_run_ready", {31'd0, cmd_ready}, 32'd1);

    // Negative retarget with final clamp
    cmd_valid = 1'b1; cmd_kin = 32'hFFFF_A000; cmd_step = 32'h8000;
    tick();
    cmd_valid = 1'b1; cmd_kin = 32'h7777_0000;
    check("neg_ready0", {31'd0, cmd_ready}, 32'd0);
    tick(); check("neg_kin1", kin, 32'h8000);
    check("neg_ready1", {31'd0, cmd_ready}, 32'd0);
    tick(); check("neg_kin2", kin, 32'h0);
    check("neg_ready2", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    tick(); check("neg_kin3", kin, 32'hFFFF_A000);
    check("neg_locked", {31'd0, locked}, 32'd1);

    // Zero step jumps straight to target
    cmd_valid = 1'b1; cmd_kin = 32'h1234; cmd_step = 32'h0;
    tick();
    cmd_valid = 1'b0;
    check("zero_accept_locked", {31'd0, locked}, 32'd0);
    tick(); check("zero_kin", kin, 32'h1234);
    check("zero_locked", {31'd0, locked}, 32'd1);

`ifdef SD_FAULT_MON_EN
    sd_out = 3'b111;
    for (int i = 0; i < 7; i++) tick();
    sd_out = 3'b010;
    tick();
    check("nofault_fault", {31'd0, fault}, 32'd0);
    check("nofault_locked", {31'd0, locked}, 32'd1);
    sd_out = 3'b000;
    for (int i = 0; i < 7; i++) tick();
    check("pretrip_fault", {31'd0, fault}, 32'd0);
    cmd_valid = 1'b1; cmd_kin = 32'h5555; cmd_step = 32'h0;
    #1;
    check("trip_ready_low", {31'd0, cmd_ready}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("trip_fault", {31'd0, fault}, 32'd1);
    check("trip_sd_reset", {31'd0, sd_reset}, 32'd1);
    check("trip_kin", kin, 32'd0);
    check("trip_fault_count", {24'd0, fault_count}, 32'd1);
    check("trip_locked", {31'd0, locked}, 32'd0);
    tick();
    check("fault_persist", {31'd0, fault}, 32'd1);
    check("fault_no_cmd_kin", kin, 32'd0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0; sd_out = 3'b010;
    check("clr_fault", {31'd0, fault}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd1);
    check("clr_count_kept", {24'd0, fault_count}, 32'd1);
    for (int i = 1; i <= 15; i++) tick();
    check("clr_hold_sd_reset", {31'd0, sd_reset}, 32'd1);
    tick();
    check("clr_idle_sd_reset", {31'd0, sd_reset}, 32'd0);
    check("clr_idle_ready", {31'd0, cmd_ready}, 32'd1);
`else
    sd_out = 3'b000;
    for (int i = 0; i < 10; i++) tick();
    check("nomon_locked", {31'd0, locked}, 32'd1);
    check("nomon_fault", {31'd0, fault}, 32'd0);
    check("nomon_fault_count", {24'd0, fault_count}, 32'd0);
    check("nomon_kin", kin, 32'h1234);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0; sd_out = 3'b010;
    check("nomon_clr_locked", {31'd0, locked}, 32'd1);
    cmd_valid = 1'b1; cmd_kin = 32'h0; cmd_step = 32'h0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("nomon_back_to_zero", kin, 32'h0);
`endif

    // Reset in the middle of a ramp
    cmd_valid = 1'b1; cmd_kin = 32'h0002_0000; cmd_step = 32'h8000;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_kin", kin, 32'h8000);
    reset = 1'b0;
    tick();
    check("mid_rst_kin", kin, 32'd0);
    check("mid_rst_sd_reset", {31'd0, sd_reset}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    check("mid_rst_locked", {31'd0, locked}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("mid_idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_idle_kin", kin, 32'd0);
    tick();
    check("mid_target_dropped", kin, 32'd0);
    check("mid_stays_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
